// File: rtl/pc_sequencer_if.sv
// Bundle between decode/branch logic and the PC sequencer: instruction
// flags and address sources in, PC load command and stall status out.
interface pc_sequencer_if;
    logic        input_flag;
    logic        output_flag;
    logic        insert;
    logic        halt;
    logic        branch_taken;
    logic        jump;
    logic        jump_reg;
    logic [31:0] pc_current;
    logic [31:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] reg_target;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        io_wait;
    logic        out_busy;
    logic        halted;

    // Decode side: presents the instruction and address sources.
    modport master (
        output input_flag, output_flag, insert, halt,
        output branch_taken, jump, jump_reg,
        output pc_current, branch_offset, jump_target, reg_target,
        input  pc_next, pc_write, io_wait, out_busy, halted
    );

    // Sequencer side: decides the PC load.
    modport slave (
        input  input_flag, output_flag, insert, halt,
        input  branch_taken, jump, jump_reg,
        input  pc_current, branch_offset, jump_target, reg_target,
        output pc_next, pc_write, io_wait, out_busy, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: decides each cycle whether the PC loads and from where.
// Stalls on IN until a fresh operator insert edge, and on OUT for a fixed
// display-hold time (skippable by insert). HALT is only left by reset.
// Outputs are Mealy: registered state plus current inputs.
module pc_sequencer #(
    parameter int OUT_HOLD_CYCLES = 5
) (
    input logic          CLK,
    input logic          reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_IN,
        ST_HOLD_OUT,
        ST_HALT
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(OUT_HOLD_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  hold_cnt, hold_cnt_nx;
    logic        insert_q;
    logic        insert_rise;

    logic [31:0]        seq_addr;
    logic signed [31:0] br_disp;
    logic [31:0]        br_addr;
    logic [31:0]        jmp_addr;
    logic [31:0]        sel_addr;

    assign insert_rise = bus.insert & ~insert_q;

    // Candidate targets, all modulo 2^32; the branch offset is a signed word count.
    assign seq_addr = bus.pc_current + 32'd4;
    assign br_disp  = $signed(bus.branch_offset) <<< 2;
    assign br_addr  = seq_addr + $unsigned(br_disp);
    assign jmp_addr = {seq_addr[31:28], bus.jump_target, 2'b00};
    assign sel_addr = bus.jump_reg     ? bus.reg_target :
                      bus.jump         ? jmp_addr       :
                      bus.branch_taken ? br_addr        :
                                         seq_addr;

    // State, hold counter and insert history register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= ST_RUN;
            hold_cnt <= 8'd0;
            insert_q <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            insert_q <= bus.insert;
        end
    end

    // Next state, counter update and PC load decision.
    always_comb begin
        state_nx     = state;
        hold_cnt_nx  = hold_cnt;
        bus.pc_write = 1'b0;
        bus.pc_next  = seq_addr;
        bus.io_wait  = 1'b0;
        bus.out_busy = 1'b0;
        bus.halted   = 1'b0;

        case (state)
            ST_RUN: begin
                bus.pc_next = sel_addr;
                if (bus.halt) begin
                    state_nx = ST_HALT;
                end else if (bus.input_flag) begin
                    // IN wins over OUT when both are flagged.
                    state_nx = ST_WAIT_IN;
                end else if (bus.output_flag) begin
                    state_nx    = ST_HOLD_OUT;
                    hold_cnt_nx = HOLD_INIT;
                end else begin
                    bus.pc_write = 1'b1;
                end
            end
            ST_WAIT_IN: begin
                bus.io_wait = 1'b1;
                if (insert_rise) begin
                    bus.pc_write = 1'b1;
                    state_nx     = ST_RUN;
                end
            end
            ST_HOLD_OUT: begin
                bus.out_busy = 1'b1;
                if (hold_cnt == 8'd0 || insert_rise) begin
                    bus.pc_write = 1'b1;
                    state_nx     = ST_RUN;
                    hold_cnt_nx  = 8'd0;
                end else begin
                    hold_cnt_nx = hold_cnt - 8'd1;
                end
            end
            ST_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase

        // Reset masks every command so an aborted stall never loads the PC.
        if (reset) begin
            bus.pc_write = 1'b0;
            bus.io_wait  = 1'b0;
            bus.out_busy = 1'b0;
            bus.halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random traffic,
// checked against a timeline-based reference model via a scoreboard queue.
module tb_pc_sequencer;

    localparam int H = 5;

    logic CLK;
    logic rst;

    pc_sequencer_if bus ();

    pc_sequencer #(.OUT_HOLD_CYCLES(H)) dut (
        .CLK   (CLK),
        .reset (rst),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic        pw;
        logic [31:0] nx;
        logic        iw;
        logic        ob;
        logic        hl;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: stall described as absolute release time / flags.
    bit m_halted;
    bit m_wait;
    int m_release;
    bit m_prev_ins;
    int cyc;

    task automatic step(input string tag);
        exp_t        e;
        logic [31:0] seq, br, jmp, sel;
        bit          rise;
        seq = bus.pc_current + 32'd4;
        br  = seq + (bus.branch_offset << 2);
        jmp = {seq[31:28], bus.jump_target, 2'b00};
        if (bus.jump_reg)          sel = bus.reg_target;
        else if (bus.jump)         sel = jmp;
        else if (bus.branch_taken) sel = br;
        else                       sel = seq;
        e.tag = tag; e.pw = 1'b0; e.nx = seq; e.iw = 1'b0; e.ob = 1'b0; e.hl = 1'b0;
        rise = bus.insert && !m_prev_ins;
        if (rst) begin
            m_halted = 0; m_wait = 0; m_release = -1; m_prev_ins = 0;
        end else begin
            if (m_halted) begin
                e.hl = 1'b1;
            end else if (m_wait) begin
                e.iw = 1'b1;
                if (rise) begin e.pw = 1'b1; m_wait = 0; end
            end else if (m_release >= 0) begin
                e.ob = 1'b1;
                if (rise || cyc == m_release) begin e.pw = 1'b1; m_release = -1; end
            end else if (bus.halt) begin
                m_halted = 1;
            end else if (bus.input_flag) begin
                m_wait = 1;
            end else if (bus.output_flag) begin
                m_release = cyc + H;
            end else begin
                e.pw = 1'b1;
                e.nx = sel;
            end
            m_prev_ins = bus.insert;
        end
        sbq.push_back(e);
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_inputs();
        bus.input_flag = 0; bus.output_flag = 0; bus.insert = 0; bus.halt = 0;
        bus.branch_taken = 0; bus.jump = 0; bus.jump_reg = 0;
        bus.pc_current = 32'h0; bus.branch_offset = 32'h0;
        bus.jump_target = 26'h0; bus.reg_target = 32'h0;
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation.
    exp_t me;
    always @(negedge CLK) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            n_cmp++;
            if (bus.pc_write !== me.pw || bus.io_wait !== me.iw ||
                bus.out_busy !== me.ob || bus.halted !== me.hl ||
                (me.pw && bus.pc_next !== me.nx)) begin
                n_bad++;
                $display("FAIL %s @%0t: got pw=%0b nx=%08h iw=%0b ob=%0b hl=%0b, want pw=%0b nx=%08h iw=%0b ob=%0b hl=%0b",
                         me.tag, $time, bus.pc_write, bus.pc_next, bus.io_wait, bus.out_busy,
                         bus.halted, me.pw, me.nx, me.iw, me.ob, me.hl);
            end
        end
    end

    initial begin
        m_halted = 0; m_wait = 0; m_release = -1; m_prev_ins = 0; cyc = 0;
        rst = 1'b1;
        clr_inputs();
        @(posedge CLK);
        #1;
        step("reset_a");
        step("reset_b");
        rst = 1'b0;

        bus.pc_current = 32'h100;
        step("seq_0x100");
        bus.branch_taken = 1; bus.branch_offset = 32'hFFFF_FFFE;
        step("branch_back");
        bus.branch_taken = 0;
        bus.pc_current = 32'hFFFF_FFFC;
        step("seq_wrap");
        bus.jump = 1; bus.jump_reg = 1; bus.reg_target = 32'h400;
        step("jr_over_j");
        bus.jump_reg = 0;
        bus.pc_current = 32'h3000_0000; bus.jump_target = 26'h10;
        step("jump");
        bus.jump = 0;

        bus.output_flag = 1;
        step("out_enter");
        bus.output_flag = 0;
        repeat (H) step("out_hold");
        step("run_after_out");

        bus.output_flag = 1;
        step("out_enter_skip");
        bus.output_flag = 0;
        step("out_skip_h1");
        bus.insert = 1;
        step("out_skip_rise");
        bus.insert = 0;
        step("run_after_skip");

        bus.insert = 1; bus.input_flag = 1;
        step("in_enter_held");
        bus.input_flag = 0;
        repeat (3) step("in_held");
        bus.insert = 0;
        repeat (10) step("in_wait");
        bus.insert = 1;
        step("in_release");
        step("run_after_in");
        bus.insert = 0;

        bus.input_flag = 1; bus.output_flag = 1;
        step("both_flags");
        bus.input_flag = 0; bus.output_flag = 0;
        step("both_wait");
        bus.insert = 1;
        step("both_release");
        bus.insert = 0;

        bus.halt = 1;
        step("halt_enter");
        bus.halt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.insert     = ~bus.insert;
            bus.input_flag = i[0];
            bus.output_flag = i[1];
            step("halted");
        end
        bus.input_flag = 0; bus.output_flag = 0; bus.insert = 0;
        rst = 1;
        step("reset_in_halt");
        rst = 0;
        step("run_after_halt");

        bus.output_flag = 1;
        step("out_enter_abort");
        bus.output_flag = 0;
        step("hold_c1");
        rst = 1;
        step("reset_in_hold");
        rst = 0;
        step("run_after_abort");
        bus.output_flag = 1;
        step("out_fresh");
        bus.output_flag = 0;
        repeat (H) step("out_fresh_hold");

        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(39) == 0);
            bus.halt         = ($urandom_range(63) == 0);
            bus.input_flag   = ($urandom_range(15) == 0);
            bus.output_flag  = ($urandom_range(15) == 0);
            if ($urandom_range(3) == 0) bus.insert = ~bus.insert;
            bus.branch_taken = $urandom_range(1);
            bus.jump         = ($urandom_range(3) == 0);
            bus.jump_reg     = ($urandom_range(3) == 0);
            bus.pc_current   = $urandom;
            bus.branch_offset = $urandom;
            bus.jump_target  = 26'($urandom);
            bus.reg_target   = $urandom;
            step("random");
        end
        rst = 0;
        clr_inputs();

        @(negedge CLK);
        #1;
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
